// File: rtl/pixel_array_controller_pkg.sv
// Shared configuration for the pixel sensor array control path: geometry and the
// controller state encoding that benches may probe.
package pixel_array_controller_pkg;

  localparam int PIXEL_BITS         = 4;
  localparam int PIXEL_ARRAY_WIDTH  = 2;
  localparam int PIXEL_ARRAY_HEIGHT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ,
    OUT_WAIT
  } ctrl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_array_controller_if.sv
// Downstream row port. valid/ready: a beat transfers on a rising edge where
// out_valid && out_ready; the master holds out_data stable while out_valid is high.
interface pixel_array_controller_if
  import pixel_array_controller_pkg::*;
#(
  parameter int DATA_W = PIXEL_BITS * PIXEL_ARRAY_WIDTH
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/pixel_array_controller_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 on phase entry gives a phase that lasts exactly N cycles.
module pixel_array_controller_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion, then one READ
// per row with each captured row handed downstream. Every output is a flop.
module pixel_array_controller #(
  parameter int PIXEL_BITS    = pixel_array_controller_pkg::PIXEL_BITS,
  parameter int ARRAY_WIDTH   = pixel_array_controller_pkg::PIXEL_ARRAY_WIDTH,
  parameter int ARRAY_HEIGHT  = pixel_array_controller_pkg::PIXEL_ARRAY_HEIGHT,
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  erase,
  output logic                                  expose,
  output logic                                  analog_ramp,
  output logic [PIXEL_BITS-1:0]                 digital_ramp,
  output logic [ARRAY_HEIGHT-1:0]               read_row,
  input  logic [ARRAY_WIDTH*PIXEL_BITS-1:0]     pixel_data,
  pixel_array_controller_if.master              out_if,
  output logic                                  frame_done,
  output pixel_array_controller_pkg::ctrl_state_t state
);

  import pixel_array_controller_pkg::*;

  localparam int DATA_W  = ARRAY_WIDTH * PIXEL_BITS;
  localparam int MAX_CYC = max_int(ERASE_CYCLES, EXPOSE_CYCLES);
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RW      = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;

  localparam logic [TW-1:0]         ERASE_LOAD  = TW'(ERASE_CYCLES - 1);
  localparam logic [TW-1:0]         EXPOSE_LOAD = TW'(EXPOSE_CYCLES - 1);
  localparam logic [RW-1:0]         LAST_ROW    = RW'(ARRAY_HEIGHT - 1);
  localparam logic [PIXEL_BITS-1:0] RAMP_MAX    = {PIXEL_BITS{1'b1}};

  ctrl_state_t state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [PIXEL_BITS-1:0]   ramp_q, ramp_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic [ARRAY_HEIGHT-1:0] read_row_q, read_row_d;
  logic                    busy_q, erase_q, expose_q, analog_q;
  logic                    timer_load;
  logic [TW-1:0]           timer_val;
  logic                    timer_done;

  pixel_array_controller_phase_timer #(.W(TW)) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    ramp_d       = ramp_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    timer_load   = 1'b0;
    timer_val    = '0;
    read_row_d   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ERASE;
          timer_load = 1'b1;
          timer_val  = ERASE_LOAD;
        end
      end
      ERASE: begin
        if (timer_done) begin
          state_d    = EXPOSE;
          timer_load = 1'b1;
          timer_val  = EXPOSE_LOAD;
        end
      end
      EXPOSE: begin
        if (timer_done) state_d = CONVERT;
      end
      CONVERT: begin
        // Ramp is cleared on exit so digital_ramp reads 0 outside CONVERT.
        if (ramp_q == RAMP_MAX) begin
          ramp_d  = '0;
          row_d   = '0;
          state_d = READ;
        end else begin
          ramp_d = ramp_q + 1'b1;
        end
      end
      READ: begin
        out_data_d  = pixel_data;
        out_valid_d = 1'b1;
        state_d     = OUT_WAIT;
      end
      OUT_WAIT: begin
        if (out_valid_q && out_if.out_ready) begin
          out_valid_d = 1'b0;
          if (row_q == LAST_ROW) begin
            frame_done_d = 1'b1;
            row_d        = '0;
            state_d      = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == READ) read_row_d[row_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      ramp_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      read_row_q   <= '0;
      busy_q       <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      analog_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      ramp_q       <= ramp_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      read_row_q   <= read_row_d;
      busy_q       <= (state_d != IDLE);
      erase_q      <= (state_d == ERASE);
      expose_q     <= (state_d == EXPOSE);
      analog_q     <= (state_d == CONVERT);
    end
  end

  assign busy             = busy_q;
  assign erase            = erase_q;
  assign expose           = expose_q;
  assign analog_ramp      = analog_q;
  assign digital_ramp     = ramp_q;
  assign read_row         = read_row_q;
  assign frame_done       = frame_done_q;
  assign state            = state_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule
